demux12_seq: RTL and testbench

- Registered 1:2 demultiplexer; the inverse of the team's 2:1 mux.
- Routes a single valid/ready input stream to one of two valid/ready output channels, selected per transfer by `sel`.
- Each output channel has a one-entry holding register, so a stalled channel never blocks traffic to the other channel.
- Sits between a single producer and two consumers in datapath examples and testbenches.

---
 rtl/demux12_seq.sv | 119 +++++++++++
 tb/tb_demux12_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/demux12_seq.sv
// Registered 1:2 valid/ready demultiplexer with a one-entry holding register per channel.
// Optional per-channel saturating accept counters are enabled by defining DEMUX12_CNT_EN.
module demux12_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] inp,
    input  logic             inp_valid,
    output logic             inp_ready,
    input  logic             sel,
    output logic [WIDTH-1:0] outp0,
    output logic             outp0_valid,
    input  logic             outp0_ready,
    output logic [WIDTH-1:0] outp1,
    output logic             outp1_valid,
    input  logic             outp1_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } ch_state_e;

    ch_state_e        st0_q, st0_d;
    ch_state_e        st1_q, st1_d;
    logic [WIDTH-1:0] data0_q, data0_d;
    logic [WIDTH-1:0] data1_q, data1_d;
    logic             accept;
    logic             load0;
    logic             load1;
    logic             drain0;
    logic             drain1;

    // Channel state and data registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st0_q   <= ST_EMPTY;
            st1_q   <= ST_EMPTY;
            data0_q <= '0;
            data1_q <= '0;
        end else begin
            st0_q   <= st0_d;
            st1_q   <= st1_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
        end
    end

    // Handshake decode and per-channel next state
    always_comb begin
        st0_d   = st0_q;
        st1_d   = st1_q;
        data0_d = data0_q;
        data1_d = data1_q;

        // A channel can take a word if it is empty or is being drained this cycle
        inp_ready = sel ? ((st1_q == ST_EMPTY) | outp1_ready)
                        : ((st0_q == ST_EMPTY) | outp0_ready);
        accept = inp_valid & inp_ready;
        load0  = accept & ~sel;
        load1  = accept & sel;
        drain0 = (st0_q == ST_FULL) & outp0_ready;
        drain1 = (st1_q == ST_FULL) & outp1_ready;

        case (st0_q)
            ST_EMPTY: if (load0) st0_d = ST_FULL;
            ST_FULL:  if (drain0 && !load0) st0_d = ST_EMPTY;
            default:  st0_d = ST_EMPTY;
        endcase

        case (st1_q)
            ST_EMPTY: if (load1) st1_d = ST_FULL;
            ST_FULL:  if (drain1 && !load1) st1_d = ST_EMPTY;
            default:  st1_d = ST_EMPTY;
        endcase

        if (load0) data0_d = inp;
        if (load1) data1_d = inp;
    end

    assign outp0       = data0_q;
    assign outp1       = data1_q;
    assign outp0_valid = (st0_q == ST_FULL);
    assign outp1_valid = (st1_q == ST_FULL);

`ifdef DEMUX12_CNT_EN
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    // Saturating accept counters; they never wrap
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (load0 && (cnt0_q != {CNT_W{1'b1}})) cnt0_d = cnt0_q + CNT_W'(1);
        if (load1 && (cnt1_q != {CNT_W{1'b1}})) cnt1_d = cnt1_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`else
    assign cnt0 = '0;
    assign cnt1 = '0;
`endif

endmodule

// File: tb/tb_demux12_seq.sv
// Self-checking bench for demux12_seq: directed steps plus randomized traffic against a
// transaction-level model of two one-word slots.
module tb_demux12_seq;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] inp;
    logic             inp_valid;
    logic             inp_ready;
    logic             sel;
    logic [WIDTH-1:0] outp0;
    logic             outp0_valid;
    logic             outp0_ready;
    logic [WIDTH-1:0] outp1;
    logic             outp1_valid;
    logic             outp1_ready;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    int n_checks = 0;
    int n_err    = 0;

    // Model: each channel is a one-word slot (valid + data) plus an accept tally
    logic             m_v   [2];
    logic [WIDTH-1:0] m_d   [2];
    int               m_cnt [2];

    demux12_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .inp         (inp),
        .inp_valid   (inp_valid),
        .inp_ready   (inp_ready),
        .sel         (sel),
        .outp0       (outp0),
        .outp0_valid (outp0_valid),
        .outp0_ready (outp0_ready),
        .outp1       (outp1),
        .outp1_valid (outp1_valid),
        .outp1_ready (outp1_ready),
        .cnt0        (cnt0),
        .cnt1        (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int k);
`ifdef DEMUX12_CNT_EN
        return 32'(m_cnt[k]);
`else
        return (k < 0) ? 32'd1 : 32'd0;
`endif
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_v[k]   = 1'b0;
            m_d[k]   = '0;
            m_cnt[k] = 0;
        end
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, ":outp0"},       32'(outp0),       32'(m_d[0]));
        chk({tag, ":outp0_valid"}, 32'(outp0_valid), 32'(m_v[0]));
        chk({tag, ":outp1"},       32'(outp1),       32'(m_d[1]));
        chk({tag, ":outp1_valid"}, 32'(outp1_valid), 32'(m_v[1]));
        chk({tag, ":cnt0"},        32'(cnt0),        exp_cnt(0));
        chk({tag, ":cnt1"},        32'(cnt1),        exp_cnt(1));
    endtask

    // One clock cycle: drive, check ready mid-cycle, advance model at the edge, check outputs
    task automatic step(input string tag, input logic v, input logic s, input logic [WIDTH-1:0] d,
                        input logic r0, input logic r1, output logic acc);
        logic rdy [2];
        logic exp_rdy;
        inp_valid   = v;
        sel         = s;
        inp         = d;
        outp0_ready = r0;
        outp1_ready = r1;
        rdy[0]      = r0;
        rdy[1]      = r1;
        #1;
        exp_rdy = !m_v[s] || rdy[s];
        chk({tag, ":inp_ready"}, 32'(inp_ready), 32'(exp_rdy));
        @(posedge clk);
        acc = v && exp_rdy;
        for (int k = 0; k < 2; k++)
            if (m_v[k] && rdy[k]) m_v[k] = 1'b0;
        if (acc) begin
            m_v[s] = 1'b1;
            m_d[s] = d;
            if (m_cnt[s] < (1 << CNT_W) - 1) m_cnt[s]++;
        end
        #1;
        chk_outputs(tag);
    endtask

    initial begin
        logic             acc;
        logic             hv;
        logic             hs;
        logic [WIDTH-1:0] hd;
        model_reset();
        rst         = 1'b1;
        inp         = '0;
        inp_valid   = 1'b0;
        sel         = 1'b0;
        outp0_ready = 1'b0;
        outp1_ready = 1'b0;

        // Reset state
        #3;
        chk_outputs("reset");
        chk("reset:inp_ready", 32'(inp_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic routing
        step("route0", 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, acc);
        chk("route0:outp0", 32'(outp0), 32'hA5);
        step("route1", 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, acc);
        chk("route1:outp1", 32'(outp1), 32'h3C);
        chk("route1:outp0_hold", 32'(outp0), 32'hA5);
        step("idle", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, acc);

        // Backpressure on channel 0
        step("bp_w1", 1'b1, 1'b0, 8'h11, 1'b0, 1'b1, acc);
        step("bp_w2_stall", 1'b1, 1'b0, 8'h22, 1'b0, 1'b1, acc);
        chk("bp_stall:not_accepted", 32'(acc), 32'd0);
        chk("bp_stall:outp0", 32'(outp0), 32'h11);
        step("bp_w2_go", 1'b1, 1'b0, 8'h22, 1'b1, 1'b1, acc);
        chk("bp_go:accepted", 32'(acc), 32'd1);
        chk("bp_go:outp0", 32'(outp0), 32'h22);

        // Independence: channel 0 stalled full, channel 1 still accepts
        step("ind_stall0", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, acc);
        step("ind_ch1", 1'b1, 1'b1, 8'h77, 1'b0, 1'b1, acc);
        chk("ind:outp1", 32'(outp1), 32'h77);
        chk("ind:outp0_valid", 32'(outp0_valid), 32'd1);

        // Full throughput, alternating channels
        for (int i = 0; i < 16; i++) begin
            step("thru", 1'b1, 1'(i), 8'(8'h40 + i), 1'b1, 1'b1, acc);
            chk("thru:accepted", 32'(acc), 32'd1);
        end

        // Reset mid-stream with a held word
        step("pre_rst", 1'b1, 1'b0, 8'h99, 1'b0, 1'b0, acc);
        inp_valid = 1'b0;
        rst       = 1'b1;
        #1;
        model_reset();
        chk_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("postrst:inp_ready", 32'(inp_ready), 32'd1);
        @(posedge clk);
        #1;

        // Counter saturation: 20 to channel 1, 3 to channel 0
        for (int i = 0; i < 20; i++) step("cnt1", 1'b1, 1'b1, 8'($urandom), 1'b1, 1'b1, acc);
        for (int i = 0; i < 3; i++)  step("cnt0", 1'b1, 1'b0, 8'($urandom), 1'b1, 1'b1, acc);
`ifdef DEMUX12_CNT_EN
        chk("cnt:cnt1_sat", 32'(cnt1), 32'hF);
        chk("cnt:cnt0", 32'(cnt0), 32'h3);
`else
        chk("cnt:cnt1_off", 32'(cnt1), 32'h0);
        chk("cnt:cnt0_off", 32'(cnt0), 32'h0);
`endif

        // Random traffic honouring the hold-while-stalled rule
        hv = 1'b0;
        hs = 1'b0;
        hd = '0;
        acc = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (!(hv && !acc)) begin
                hv = ($urandom_range(0, 9) < 7);
                hs = 1'($urandom);
                hd = 8'($urandom);
            end
            step("rand", hv, hs, hd, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), acc);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
